fetch_stage: RTL and testbench

- PC register, next-PC selection and IF/ID pipeline latch for the 5-stage 16-bit pipeline.
- Feeds the decode stage, and consumes the decode-stage hazard stall and the decode-stage branch resolution (BR/B resolved in ID).
- Inserts bubbles on instruction-memory miss and on taken-branch flush.
- Freezes fetch after an HLT is latched.

---
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: decode-side control, imem read port and IF/ID latch outputs.
// Pure wiring, no latency of its own.
// Backpressure is carried by stall_en (decode) and imem_ready (memory).
interface fetch_stage_if;
    logic        stall_en;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_instr;
    logic        imem_ready;
    logic [15:0] imem_addr;
    logic        imem_req;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;

    // Seen from the fetch stage itself
    modport master (
        input  stall_en, branch_taken, branch_target, imem_instr, imem_ready,
        output imem_addr, imem_req, if_id_instr, if_id_pc_plus2, if_id_valid, halted
    );

    // Seen from the surrounding pipeline / memory
    modport slave (
        output stall_en, branch_taken, branch_target, imem_instr, imem_ready,
        input  imem_addr, imem_req, if_id_instr, if_id_pc_plus2, if_id_valid, halted
    );
endinterface

// File: rtl/fetch_stage.sv
// PC register, next-PC select and IF/ID latch for the 16-bit 5-stage pipeline.
// Latency: instruction fetched at edge N is on the IF/ID outputs right after edge N.
// Backpressure: decode stall holds everything; imem miss holds PC and inserts bubbles.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic [15:0] pc_plus2;

    // Sequential increment wraps naturally at 16 bits
    assign pc_plus2 = pc_q + 16'd2;

    // Next-state select in priority order: stall, redirect, halt, miss, fetch
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus2_d = pc_plus2_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        if (bus.stall_en) begin
            // Branch resolution is not trustworthy while decode is stalled
        end else if (bus.branch_taken) begin
            // Redirect and squash the wrong-path instruction, including a latched HLT
            pc_d       = bus.branch_target;
            instr_d    = NOP_INSTR;
            pc_plus2_d = 16'h0000;
            valid_d    = 1'b0;
            halted_d   = 1'b0;
        end else if (halted_q) begin
            // Frozen until a redirect or reset
        end else if (!bus.imem_ready) begin
            instr_d    = NOP_INSTR;
            pc_plus2_d = 16'h0000;
            valid_d    = 1'b0;
        end else begin
            instr_d    = bus.imem_instr;
            pc_plus2_d = pc_plus2;
            valid_d    = 1'b1;
            if (bus.imem_instr[15:12] == HLT_OPCODE) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_plus2;
            end
        end
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.imem_addr      = pc_q;
    assign bus.imem_req       = ~halted_q & rst_n;
    assign bus.if_id_instr    = instr_q;
    assign bus.if_id_pc_plus2 = pc_plus2_q;
    assign bus.if_id_valid    = valid_q;
    assign bus.halted         = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
    } ifid_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    ifid_t sb_q[$];

    fetch_stage_if bus();

    fetch_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic bt, input logic [15:0] tgt,
                         input logic rdy, input logic [15:0] ins);
        bus.stall_en      = st;
        bus.branch_taken  = bt;
        bus.branch_target = tgt;
        bus.imem_ready    = rdy;
        bus.imem_instr    = ins;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] ins,
                            input logic [15:0] pc2, input logic vld);
        chk({tag, "_instr"}, bus.if_id_instr, ins);
        chk({tag, "_pc2"}, bus.if_id_pc_plus2, pc2);
        chk({tag, "_valid"}, {15'd0, bus.if_id_valid}, {15'd0, vld});
    endtask

    // One fetch cycle: expect PC=addr, push expected IF/ID result, clock, pop and compare
    task automatic fetch(input string tag, input logic [15:0] addr,
                         input logic rdy, input logic [15:0] ins);
        ifid_t e;
        logic [15:0] nxt;
        nxt = addr + 16'd2;
        chk({tag, "_addr"}, bus.imem_addr, addr);
        chk({tag, "_req"}, {15'd0, bus.imem_req}, 16'd1);
        if (rdy) sb_q.push_back('{instr: ins, pc2: nxt, valid: 1'b1});
        else     sb_q.push_back('{instr: 16'h0000, pc2: 16'h0000, valid: 1'b0});
        drive(1'b0, 1'b0, 16'h0000, rdy, ins);
        tick();
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk_ifid(tag, e.instr, e.pc2, e.valid);
        end
    endtask

    // One redirect cycle: IF/ID flushed, PC lands on the target
    task automatic redirect(input string tag, input logic [15:0] tgt);
        drive(1'b0, 1'b1, tgt, 1'b1, 16'h6002);
        tick();
        chk({tag, "_addr"}, bus.imem_addr, tgt);
        chk_ifid(tag, 16'h0000, 16'h0000, 1'b0);
        chk({tag, "_halted"}, {15'd0, bus.halted}, 16'd0);
    endtask

    initial begin
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1123);

        // Reset
        tick();
        chk("rst_req", {15'd0, bus.imem_req}, 16'd0);
        tick();
        chk("rst_addr", bus.imem_addr, 16'h0000);
        chk_ifid("rst", 16'h0000, 16'h0000, 1'b0);
        chk("rst_halted", {15'd0, bus.halted}, 16'd0);
        rst_n = 1'b1;
        #1;

        // Streaming fetch
        fetch("s0", 16'h0000, 1'b1, 16'h1123);
        fetch("s1", 16'h0002, 1'b1, 16'h2456);
        fetch("s2", 16'h0004, 1'b1, 16'h3789);

        // Stall with a coincident branch: everything holds, branch ignored
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 16'h0040, 1'b1, 16'h4AAA);
            tick();
            chk("stall_addr", bus.imem_addr, 16'h0006);
            chk_ifid("stall", 16'h3789, 16'h0006, 1'b1);
        end
        fetch("after_stall", 16'h0006, 1'b1, 16'h5001);

        // Taken branch: one bubble, then target fetched
        redirect("br", 16'h0100);
        fetch("br_tgt", 16'h0100, 1'b1, 16'h7003);

        // Memory miss for three cycles at 0010
        redirect("br_miss", 16'h0010);
        for (int i = 0; i < 3; i++) fetch("miss", 16'h0010, 1'b0, 16'h2222);
        fetch("miss_done", 16'h0010, 1'b1, 16'h8004);

        // HLT freezes fetch until a taken branch
        redirect("br_hlt", 16'h0020);
        fetch("hlt", 16'h0020, 1'b1, 16'hF000);
        chk("hlt_halted", {15'd0, bus.halted}, 16'd1);
        chk("hlt_req", {15'd0, bus.imem_req}, 16'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 16'h0000, (i != 2), 16'h1111);
            tick();
            chk("hold_addr", bus.imem_addr, 16'h0020);
            chk_ifid("hold", 16'hF000, 16'h0022, 1'b1);
            chk("hold_halted", {15'd0, bus.halted}, 16'd1);
        end
        redirect("unhalt", 16'h0030);
        fetch("resume", 16'h0030, 1'b1, 16'h9005);

        // PC wrap at the top of the address space
        redirect("br_wrap", 16'hFFFE);
        fetch("wrap", 16'hFFFE, 1'b1, 16'hA006);
        fetch("wrapped", 16'h0000, 1'b1, 16'hB007);

        // Reset arriving during a miss
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        rst_n = 1'b0;
        #1;
        chk("mrst_req_comb", {15'd0, bus.imem_req}, 16'd0);
        tick();
        chk("mrst_addr", bus.imem_addr, 16'h0000);
        chk_ifid("mrst", 16'h0000, 16'h0000, 1'b0);
        chk("mrst_halted", {15'd0, bus.halted}, 16'd0);
        rst_n = 1'b1;
        #1;
        fetch("post_rst", 16'h0000, 1'b1, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
